// File: rtl/write_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// write_bus_arbiter_pkg
// Shared definitions for the result/write bus arbitration logic.
// Holds the default datapath widths (matching WordWidth,
// Def_RegisterSelectWidth and ByteWidth used elsewhere in the core), the
// arbiter state encoding and the width of the lock counter.
// No ports: this is a package.
// -----------------------------------------------------------------------------
package write_bus_arbiter_pkg;

    // Default result word width, same as the core's WordWidth.
    localparam int WORD_WIDTH_DEF = 32;

    // Default register number width, same as Def_RegisterSelectWidth.
    localparam int REG_SEL_WIDTH_DEF = 4;

    // Default component/entry tag width, same as ByteWidth.
    localparam int TAG_WIDTH_DEF = 8;

    // The lock counter must hold values up to the largest supported MAX_LOCK (15).
    localparam int LOCK_CNT_WIDTH = 4;

    // IDLE arbitrates round-robin every cycle; LOCKED keeps the bus with one owner.
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arbState_t;

endpackage

// File: rtl/write_bus_arbiter_rr_priority_pick.sv
// -----------------------------------------------------------------------------
// rr_priority_pick
// Combinational rotating-priority picker. Starting at startPtr and moving
// upward (wrapping from NUM_REQ-1 to 0), the first set bit of request wins.
// Kept separate so the load/store queue arbitration can reuse it.
//
// Ports:
//   request      in   NUM_REQ  request vector
//   startPtr     in   IDX_W    index with highest priority this cycle
//   grantOneHot  out  NUM_REQ  one-hot winner, all zero when nothing requests
//   grantIndex   out  IDX_W    binary index of the winner (0 when none)
//   grantValid   out  1        a winner was found
// -----------------------------------------------------------------------------
module rr_priority_pick #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] request,
    input  logic [IDX_W-1:0]   startPtr,
    output logic [NUM_REQ-1:0] grantOneHot,
    output logic [IDX_W-1:0]   grantIndex,
    output logic               grantValid
);

    // Walk the requesters in priority order beginning at startPtr; once a
    // winner is recorded, later candidates are ignored. The one-hot form is
    // derived from the binary index so the two can never disagree.
    always_comb begin
        int idx;
        idx         = 0;
        grantOneHot = '0;
        grantIndex  = '0;
        grantValid  = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = (int'(startPtr) + off) % NUM_REQ;
            if (!grantValid && request[idx]) begin
                grantValid = 1'b1;
                grantIndex = IDX_W'(idx);
            end
        end
        if (grantValid) begin
            grantOneHot[grantIndex] = 1'b1;
        end
    end

endmodule

// File: rtl/write_bus_arbiter.sv
// -----------------------------------------------------------------------------
// write_bus_arbiter
// Shares the single Tomasulo result/write bus between NUM_REQ function
// components. One requester is granted per cycle by round-robin; a requester
// may hold the bus for up to MAX_LOCK consecutive grants by asserting in_Lock.
// The winner's result, destination register and producer tag are registered
// onto the bus one cycle after the grant.
//
// Ports:
//   clock                    in   1                       rising-edge clock
//   reset                    in   1                       synchronous, active-high
//   in_WriteRequest          in   NUM_REQ                 request, held until granted
//   in_Lock                  in   NUM_REQ                 keep the bus after this grant
//   in_RegWrite              in   NUM_REQ                 result also writes the register file
//   in_Data                  in   NUM_REQ*WORD_WIDTH      flattened result words
//   in_RegisterNumber        in   NUM_REQ*REG_SEL_WIDTH   flattened destination registers
//   in_ComponentEntry        in   NUM_REQ*TAG_WIDTH       flattened producer tags
//   out_Grant                out  NUM_REQ                 one-hot grant, combinational
//   out_WriteBus             out  WORD_WIDTH              registered result word
//   out_WriteRegisterNumber  out  REG_SEL_WIDTH           registered destination
//   out_WriteComponentEntry  out  TAG_WIDTH               registered producer tag
//   out_WriteValid           out  1                       bus holds a valid broadcast
//   out_WriteRegisterEnable  out  1                       valid broadcast that writes the RF
// -----------------------------------------------------------------------------
module write_bus_arbiter
    import write_bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int WORD_WIDTH    = WORD_WIDTH_DEF,
    parameter int REG_SEL_WIDTH = REG_SEL_WIDTH_DEF,
    parameter int TAG_WIDTH     = TAG_WIDTH_DEF,
    parameter int MAX_LOCK      = 4
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               in_WriteRequest,
    input  logic [NUM_REQ-1:0]               in_Lock,
    input  logic [NUM_REQ-1:0]               in_RegWrite,
    input  logic [NUM_REQ*WORD_WIDTH-1:0]    in_Data,
    input  logic [NUM_REQ*REG_SEL_WIDTH-1:0] in_RegisterNumber,
    input  logic [NUM_REQ*TAG_WIDTH-1:0]     in_ComponentEntry,
    output logic [NUM_REQ-1:0]               out_Grant,
    output logic [WORD_WIDTH-1:0]            out_WriteBus,
    output logic [REG_SEL_WIDTH-1:0]         out_WriteRegisterNumber,
    output logic [TAG_WIDTH-1:0]             out_WriteComponentEntry,
    output logic                             out_WriteValid,
    output logic                             out_WriteRegisterEnable
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arbState_t                 state;
    arbState_t                 stateNext;
    logic [IDX_W-1:0]          rrPtr;
    logic [IDX_W-1:0]          rrPtrNext;
    logic [IDX_W-1:0]          owner;
    logic [IDX_W-1:0]          ownerNext;
    logic [LOCK_CNT_WIDTH-1:0] lockCount;
    logic [LOCK_CNT_WIDTH-1:0] lockCountNext;
    logic [NUM_REQ-1:0]        pickOneHot;
    logic [IDX_W-1:0]          pickIndex;
    logic                      pickValid;
    logic                      ownerHolds;
    logic [IDX_W-1:0]          winner;
    logic                      grantValid;

    // Pointer that follows a winner, wrapping at NUM_REQ (which need not be a
    // power of two).
    function automatic logic [IDX_W-1:0] nextPtr(input logic [IDX_W-1:0] idx);
        if (idx == IDX_W'(NUM_REQ - 1)) begin
            return '0;
        end
        return idx + IDX_W'(1);
    endfunction

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .request     (in_WriteRequest),
        .startPtr    (rrPtr),
        .grantOneHot (pickOneHot),
        .grantIndex  (pickIndex),
        .grantValid  (pickValid)
    );

    // While locked, the owner keeps the bus only as long as it still requests;
    // a dropped owner request falls straight through to round-robin.
    assign ownerHolds = (state == LOCKED) && in_WriteRequest[owner];

    // State register: arbitration state, fairness pointer, lock owner and the
    // number of grants the owner has received in the current lock.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            rrPtr     <= '0;
            owner     <= '0;
            lockCount <= '0;
        end else begin
            state     <= stateNext;
            rrPtr     <= rrPtrNext;
            owner     <= ownerNext;
            lockCount <= lockCountNext;
        end
    end

    // Next-state logic. A held lock advances its counter and is released when
    // the owner stops asking for it or the grant budget is used up. Otherwise
    // the round-robin winner moves the pointer past itself and may start a new
    // lock. The pointer is not touched while the owner holds the bus, so after
    // release the search resumes just past the owner.
    always_comb begin
        stateNext     = state;
        rrPtrNext     = rrPtr;
        ownerNext     = owner;
        lockCountNext = lockCount;
        if (ownerHolds) begin
            lockCountNext = lockCount + LOCK_CNT_WIDTH'(1);
            if (!in_Lock[owner] || (lockCountNext >= LOCK_CNT_WIDTH'(MAX_LOCK))) begin
                stateNext     = IDLE;
                lockCountNext = '0;
            end
        end else begin
            stateNext     = IDLE;
            lockCountNext = '0;
            if (pickValid) begin
                rrPtrNext = nextPtr(pickIndex);
                if (in_Lock[pickIndex] && (MAX_LOCK > 1)) begin
                    stateNext     = LOCKED;
                    ownerNext     = pickIndex;
                    lockCountNext = LOCK_CNT_WIDTH'(1);
                end
            end
        end
    end

    // Grant outputs. Reset suppresses every grant; a holding owner overrides
    // the round-robin pick; otherwise the picker's result is used directly.
    always_comb begin
        out_Grant  = '0;
        winner     = pickIndex;
        grantValid = 1'b0;
        if (reset) begin
            out_Grant  = '0;
            grantValid = 1'b0;
        end else if (ownerHolds) begin
            winner            = owner;
            grantValid        = 1'b1;
            out_Grant[owner]  = 1'b1;
        end else if (pickValid) begin
            winner     = pickIndex;
            grantValid = 1'b1;
            out_Grant  = pickOneHot;
        end
    end

    // Bus registers. The granted requester's slice is captured on the grant
    // edge; without a grant the valid flags drop while the payload registers
    // keep their last contents.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_WriteBus            <= '0;
            out_WriteRegisterNumber <= '0;
            out_WriteComponentEntry <= '0;
            out_WriteValid          <= 1'b0;
            out_WriteRegisterEnable <= 1'b0;
        end else if (grantValid) begin
            out_WriteBus            <= in_Data[winner*WORD_WIDTH +: WORD_WIDTH];
            out_WriteRegisterNumber <= in_RegisterNumber[winner*REG_SEL_WIDTH +: REG_SEL_WIDTH];
            out_WriteComponentEntry <= in_ComponentEntry[winner*TAG_WIDTH +: TAG_WIDTH];
            out_WriteValid          <= 1'b1;
            out_WriteRegisterEnable <= in_RegWrite[winner];
        end else begin
            out_WriteValid          <= 1'b0;
            out_WriteRegisterEnable <= 1'b0;
        end
    end

endmodule

// File: tb/tb_write_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_write_bus_arbiter
// Self-checking bench for write_bus_arbiter. Directed scenarios followed by a
// randomized phase; every cycle the grant and bus outputs are compared with a
// behavioural model of the arbitration rules kept in the bench.
// -----------------------------------------------------------------------------
module tb_write_bus_arbiter;

    localparam int NUM_REQ       = 4;
    localparam int WORD_WIDTH    = 32;
    localparam int REG_SEL_WIDTH = 4;
    localparam int TAG_WIDTH     = 8;
    localparam int MAX_LOCK      = 4;
    localparam int STARVE_BOUND  = (NUM_REQ - 1) * MAX_LOCK + 1;

    logic                             clock = 1'b0;
    logic                             reset;
    logic [NUM_REQ-1:0]               in_WriteRequest;
    logic [NUM_REQ-1:0]               in_Lock;
    logic [NUM_REQ-1:0]               in_RegWrite;
    logic [NUM_REQ*WORD_WIDTH-1:0]    in_Data;
    logic [NUM_REQ*REG_SEL_WIDTH-1:0] in_RegisterNumber;
    logic [NUM_REQ*TAG_WIDTH-1:0]     in_ComponentEntry;
    logic [NUM_REQ-1:0]               out_Grant;
    logic [WORD_WIDTH-1:0]            out_WriteBus;
    logic [REG_SEL_WIDTH-1:0]         out_WriteRegisterNumber;
    logic [TAG_WIDTH-1:0]             out_WriteComponentEntry;
    logic                             out_WriteValid;
    logic                             out_WriteRegisterEnable;

    // Requester-side view of the inputs, packed onto the DUT ports each cycle.
    logic                     resetV;
    logic [NUM_REQ-1:0]       reqV;
    logic [NUM_REQ-1:0]       lockV;
    logic [NUM_REQ-1:0]       regWrV;
    logic [WORD_WIDTH-1:0]    dataA [NUM_REQ];
    logic [REG_SEL_WIDTH-1:0] regA  [NUM_REQ];
    logic [TAG_WIDTH-1:0]     tagA  [NUM_REQ];

    // Reference model state.
    int                       mPtr;
    bit                       mLocked;
    int                       mOwner;
    int                       mCount;
    logic                     expValid;
    logic                     expRegEn;
    logic [WORD_WIDTH-1:0]    expData;
    logic [REG_SEL_WIDTH-1:0] expReg;
    logic [TAG_WIDTH-1:0]     expTag;
    int                       waitCnt [NUM_REQ];

    int                       lastGrant;
    logic [NUM_REQ-1:0]       dutGrant;
    int                       checks = 0;
    int                       errors = 0;

    write_bus_arbiter #(
        .NUM_REQ       (NUM_REQ),
        .WORD_WIDTH    (WORD_WIDTH),
        .REG_SEL_WIDTH (REG_SEL_WIDTH),
        .TAG_WIDTH     (TAG_WIDTH),
        .MAX_LOCK      (MAX_LOCK)
    ) dut (
        .clock                   (clock),
        .reset                   (reset),
        .in_WriteRequest         (in_WriteRequest),
        .in_Lock                 (in_Lock),
        .in_RegWrite             (in_RegWrite),
        .in_Data                 (in_Data),
        .in_RegisterNumber       (in_RegisterNumber),
        .in_ComponentEntry       (in_ComponentEntry),
        .out_Grant               (out_Grant),
        .out_WriteBus            (out_WriteBus),
        .out_WriteRegisterNumber (out_WriteRegisterNumber),
        .out_WriteComponentEntry (out_WriteComponentEntry),
        .out_WriteValid          (out_WriteValid),
        .out_WriteRegisterEnable (out_WriteRegisterEnable)
    );

    // Free-running clock, period 10.
    always #5 clock = ~clock;

    // Safety net so the run always ends on its own.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not reach its end");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic driveInputs();
        reset           = resetV;
        in_WriteRequest = reqV;
        in_Lock         = lockV;
        in_RegWrite     = regWrV;
        for (int i = 0; i < NUM_REQ; i++) begin
            in_Data[i*WORD_WIDTH +: WORD_WIDTH]             = dataA[i];
            in_RegisterNumber[i*REG_SEL_WIDTH +: REG_SEL_WIDTH] = regA[i];
            in_ComponentEntry[i*TAG_WIDTH +: TAG_WIDTH]     = tagA[i];
        end
    endtask

    task automatic newResult(input int i);
        dataA[i]  = $urandom;
        regA[i]   = REG_SEL_WIDTH'($urandom);
        tagA[i]   = TAG_WIDTH'($urandom);
        regWrV[i] = 1'($urandom);
    endtask

    // Who should win this cycle: a requesting lock owner keeps the bus;
    // otherwise the first requester at or after the pointer, wrapping around.
    function automatic int modelGrant();
        int idx;
        if (resetV) return -1;
        if (mLocked && reqV[mOwner]) return mOwner;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = (mPtr + off) % NUM_REQ;
            if (reqV[idx]) return idx;
        end
        return -1;
    endfunction

    // Advance the model across one clock edge given this cycle's winner.
    task automatic commitModel(input int g);
        if (resetV) begin
            mPtr = 0; mLocked = 0; mOwner = 0; mCount = 0;
            expValid = 0; expRegEn = 0; expData = '0; expReg = '0; expTag = '0;
            for (int i = 0; i < NUM_REQ; i++) waitCnt[i] = 0;
            return;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!reqV[i]) begin
                waitCnt[i] = 0;
            end else if (g == i) begin
                checkOutput($sformatf("starve%0d", i), 32'(waitCnt[i] >= STARVE_BOUND), 32'd0);
                waitCnt[i] = 0;
            end else begin
                waitCnt[i]++;
            end
        end
        if (g >= 0) begin
            expValid = 1; expRegEn = regWrV[g];
            expData = dataA[g]; expReg = regA[g]; expTag = tagA[g];
        end else begin
            expValid = 0; expRegEn = 0;
        end
        if (mLocked && reqV[mOwner]) begin
            mCount++;
            if (!lockV[mOwner] || mCount >= MAX_LOCK) mLocked = 0;
        end else begin
            mLocked = 0;
            if (g >= 0) begin
                mPtr = (g + 1) % NUM_REQ;
                if (lockV[g] && MAX_LOCK > 1) begin
                    mLocked = 1; mOwner = g; mCount = 1;
                end
            end
        end
    endtask

    // One bus cycle: drive inputs after the falling edge, compare grant and
    // bus against the model, then let the rising edge happen and update it.
    task automatic applyStimulus();
        int g;
        @(negedge clock);
        driveInputs();
        #1;
        g = modelGrant();
        checkOutput("grant", 32'(out_Grant), (g >= 0) ? (32'd1 << g) : 32'd0);
        checkOutput("valid", 32'(out_WriteValid), 32'(expValid));
        checkOutput("regEnable", 32'(out_WriteRegisterEnable), 32'(expRegEn));
        checkOutput("busData", out_WriteBus, expData);
        checkOutput("busReg", 32'(out_WriteRegisterNumber), 32'(expReg));
        checkOutput("busTag", 32'(out_WriteComponentEntry), 32'(expTag));
        dutGrant = out_Grant;
        @(posedge clock);
        commitModel(g);
        lastGrant = g;
    endtask

    initial begin
        logic [NUM_REQ-1:0] seqRr   [4];
        logic [NUM_REQ-1:0] seqLock [5];
        logic [NUM_REQ-1:0] seqRel  [4];
        seqRr   = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        seqLock = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b1000};
        seqRel  = '{4'b0001, 4'b0001, 4'b0010, 4'b0100};

        mPtr = 0; mLocked = 0; mOwner = 0; mCount = 0;
        expValid = 0; expRegEn = 0; expData = '0; expReg = '0; expTag = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            waitCnt[i] = 0;
            newResult(i);
        end
        lastGrant = -1;

        // Reset with everyone requesting: no grant, bus idle.
        resetV = 1; reqV = '1; lockV = '0;
        driveInputs();
        applyStimulus();
        applyStimulus();
        checkOutput("rstGrant", 32'(dutGrant), 32'd0);

        // Round-robin with all four requesting continuously.
        resetV = 0;
        applyStimulus();
        checkOutput("firstGrant", 32'(dutGrant), 32'd1);
        newResult(0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus();
            checkOutput($sformatf("rrSeq%0d", k), 32'(dutGrant), 32'(seqRr[k]));
            newResult(lastGrant);
        end

        // Requester 2 alone with a known payload, then the same with RegWrite=0.
        reqV = '0;
        applyStimulus();
        reqV = 4'b0100;
        dataA[2] = 32'h12345678; regA[2] = 4'd5; tagA[2] = 8'h21; regWrV[2] = 1'b1;
        applyStimulus();
        #2;
        checkOutput("fixedData", out_WriteBus, 32'h12345678);
        checkOutput("fixedReg", 32'(out_WriteRegisterNumber), 32'd5);
        checkOutput("fixedTag", 32'(out_WriteComponentEntry), 32'h21);
        checkOutput("fixedRegEn", 32'(out_WriteRegisterEnable), 32'd1);
        regWrV[2] = 1'b0;
        applyStimulus();
        #2;
        checkOutput("fixedValid", 32'(out_WriteValid), 32'd1);
        checkOutput("fixedRegEnOff", 32'(out_WriteRegisterEnable), 32'd0);

        // Move the pointer to 0 by serving requester 3 alone.
        reqV = 4'b1000;
        applyStimulus();
        reqV = '0;
        applyStimulus();

        // Requester 1 locks continuously, requester 3 waits out MAX_LOCK grants.
        reqV = 4'b1010; lockV = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            applyStimulus();
            checkOutput($sformatf("lockSeq%0d", k), 32'(dutGrant), 32'(seqLock[k]));
            newResult(lastGrant);
        end
        reqV = '0; lockV = '0;
        applyStimulus();

        // Requester 0 locks for two grants then releases; 1 and 2 follow back to back.
        reqV = 4'b0111; lockV = 4'b0001;
        applyStimulus();
        checkOutput("relSeq0", 32'(dutGrant), 32'(seqRel[0]));
        newResult(0); lockV[0] = 1'b0;
        applyStimulus();
        checkOutput("relSeq1", 32'(dutGrant), 32'(seqRel[1]));
        reqV[0] = 1'b0;
        applyStimulus();
        checkOutput("relSeq2", 32'(dutGrant), 32'(seqRel[2]));
        reqV[1] = 1'b0;
        applyStimulus();
        checkOutput("relSeq3", 32'(dutGrant), 32'(seqRel[3]));
        reqV = '0;
        applyStimulus();

        // Reset while requester 2 holds a lock: lock dropped, pointer back to 0.
        reqV = 4'b0100; lockV = 4'b0100;
        applyStimulus();
        checkOutput("lockOwner2", 32'(dutGrant), 32'b0100);
        newResult(2);
        resetV = 1;
        applyStimulus();
        checkOutput("rstLockGrant", 32'(dutGrant), 32'd0);
        #2;
        checkOutput("rstLockValid", 32'(out_WriteValid), 32'd0);
        resetV = 0; reqV = 4'b1100; lockV = '0;
        applyStimulus();
        checkOutput("afterRstGrant", 32'(dutGrant), 32'b0100);
        reqV = '0;
        applyStimulus();

        // Randomized traffic obeying the request/grant handshake.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            resetV = ($urandom_range(0, 299) == 0);
            applyStimulus();
            if (lastGrant >= 0) begin
                if ($urandom_range(0, 1) == 1) begin
                    newResult(lastGrant);
                    lockV[lastGrant] = 1'($urandom);
                end else begin
                    reqV[lastGrant] = 1'b0;
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!reqV[i] && (i != lastGrant) && ($urandom_range(0, 2) == 0)) begin
                    reqV[i] = 1'b1;
                    lockV[i] = 1'($urandom);
                    newResult(i);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/write_bus_arbiter.md
Name: write_bus_arbiter

Overview:
- Shares the single Tomasulo result/write bus between NUM_REQ function components (ALU, multiplier, load/store, ...).
- Picks one requester per cycle by round-robin, with an optional bounded lock for multi-register writebacks.
- Registers the winner's data, destination register and component/entry tag onto the bus for the register file and listening reservation entries.
- Replaces the single-channel pass-through arbitration.

Parameters:
- NUM_REQ, 4, number of requesting function components (2..8).
- WORD_WIDTH, 32, result data width.
- REG_SEL_WIDTH, 4, register number width.
- TAG_WIDTH, 8, component/entry tag width.
- MAX_LOCK, 4, maximum consecutive grants to one locked requester (1..15).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_WriteRequest  in  NUM_REQ  per-requester request; held until granted.
- in_Lock  in  NUM_REQ  requester wants to keep the bus after this grant.
- in_RegWrite  in  NUM_REQ  result also writes the register file (0 = tag broadcast only).
- in_Data  in  NUM_REQ*WORD_WIDTH  flattened result words, requester i at slice i.
- in_RegisterNumber  in  NUM_REQ*REG_SEL_WIDTH  flattened destination registers.
- in_ComponentEntry  in  NUM_REQ*TAG_WIDTH  flattened producer tags.
- out_Grant  out  NUM_REQ  one-hot grant, combinational, same cycle as request.
- out_WriteBus  out  WORD_WIDTH  registered result word.
- out_WriteRegisterNumber  out  REG_SEL_WIDTH  registered destination.
- out_WriteComponentEntry  out  TAG_WIDTH  registered producer tag.
- out_WriteValid  out  1  bus holds a valid broadcast this cycle.
- out_WriteRegisterEnable  out  1  out_WriteValid & captured RegWrite.

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high.
- Reset: all registered outputs 0, rr pointer 0, state IDLE, lock_count 0. out_Grant is forced 0 while reset is high. Reset mid-lock drops the lock; the pending data is not broadcast.
- Grant:
  - At most one bit of out_Grant is set.
  - A bit is set only if the matching in_WriteRequest bit is high.
  - No requests gives out_Grant = 0.
- Capture: at the edge where out_Grant[i] = 1, latch slice i of Data/RegisterNumber/ComponentEntry/RegWrite into the output registers and set out_WriteValid = 1. Latency is 1 cycle from grant to bus.
- No grant: out_WriteValid = 0 and out_WriteRegisterEnable = 0 next cycle. Data/number/tag registers hold their last values.
- Requester handshake: sample out_Grant at the edge. Granted: present the next result or drop the request. Not granted: hold all inputs stable.
- IDLE state:
  - Round-robin search starts at rr_ptr and goes upward, wrapping NUM_REQ-1 to 0.
  - First requester found wins. rr_ptr <= (winner+1) mod NUM_REQ.
  - If the winner's in_Lock = 1 and MAX_LOCK > 1: state <= LOCKED, owner <= winner, lock_count <= 1.
- LOCKED state:
  - If the owner's request is high: the owner is granted regardless of others, and lock_count increments.
  - Leave LOCKED for IDLE when any of these is true: owner's in_Lock = 0 on the granted cycle; lock_count reaches MAX_LOCK; owner's request is low.
  - When left because the owner's request is low, the same cycle arbitrates round-robin as in IDLE (no bubble).
  - rr_ptr stays at owner+1 throughout, so the lock never skews fairness after release.
- Starvation bound: any continuously asserted request is granted within (NUM_REQ-1)*MAX_LOCK + 1 cycles.
- Simultaneous events: a new request arriving in the same cycle as a lock release is arbitrated that cycle.
- Inputs of non-granted requesters are ignored.

Decomposition:
- Shared package holds: WORD_WIDTH/REG_SEL_WIDTH/TAG_WIDTH defaults (aligned with WordWidth, Def_RegisterSelectWidth, ByteWidth), the IDLE/LOCKED state encodings, and the lock_count width.
- One sub-module, rr_priority_pick: combinational, takes request vector and start pointer, returns one-hot plus index. Reused by later load/store queue arbitration.

Test Plan:
- Reset with all requests = 1111 -> out_Grant = 0000 and out_WriteValid = 0 during reset. First cycle after reset: grant 0001, next cycle out_WriteValid = 1 with requester 0's data.
- All four request continuously, no lock -> grants 0001, 0010, 0100, 1000, 0001; each bus cycle carries the matching tag/data one cycle later.
- Requester 2 requests alone with data 0x12345678, reg 5, tag 0x21, RegWrite = 1 -> next cycle bus = 0x12345678, reg 5, tag 0x21, out_WriteRegisterEnable = 1. Repeat with RegWrite = 0 -> valid = 1, register enable = 0.
- Requester 1 locks continuously, MAX_LOCK = 4, requester 3 requesting -> grants 1,1,1,1,3; requester 3 is served at the 5th grant.
- Requester 0 locks for 2 grants then drops in_Lock, requesters 1 and 2 waiting -> sequence 0,0,1,2; no idle cycle between grants.
- Reset asserted in LOCKED with owner 2 -> state IDLE, rr_ptr 0, no broadcast. After reset, requesters {2,3} -> grant 0100 (search from pointer 0).
